// File: rtl/pipe_mult_acc.sv
// Three-stage pipelined multiply-accumulate: operand register, Dadda carry-save
// reduction with Baugh-Wooley signed correction, then carry-propagate add and accumulate.
module pipe_mult_acc #(
  parameter int WIDTH1 = 8,
  parameter int WIDTH2 = 8,
  parameter int ACC_W  = WIDTH1 + WIDTH2 + 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WIDTH1-1:0] a_i,
  input  logic [WIDTH2-1:0] b_i,
  input  logic              tc_i,
  input  logic              acc_clr_i,
  input  logic              acc_en_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ACC_W-1:0]  acc_out_o,
  output logic              ovf_o
);

  localparam int PW   = WIDTH1 + WIDTH2;
  localparam int MINW = (WIDTH1 < WIDTH2) ? WIDTH1 : WIDTH2;
  localparam int MAXH = MINW + 3;
  localparam int NDS  = 16;

  if (ACC_W < PW) begin : g_acc_w_check
    $error("pipe_mult_acc: ACC_W must be >= WIDTH1+WIDTH2");
  end

  // Builds the partial-product bit matrix column by column and reduces it with
  // Dadda stage targets (2,3,4,6,9,...) down to two rows.
  function automatic logic [2*PW-1:0] dadda_reduce(
    input logic [WIDTH1-1:0] a,
    input logic [WIDTH2-1:0] b,
    input logic              tc
  );
    logic          cur [PW][MAXH];
    logic          nxt [PW][MAXH];
    int            h   [PW];
    int            nh  [PW];
    int            d   [NDS];
    int            hmax;
    int            idx;
    int            excess;
    logic          cy;
    logic [PW-1:0] v0;
    logic [PW-1:0] v1;

    for (int c = 0; c < PW; c++) begin
      h[c]  = 0;
      nh[c] = 0;
      for (int r = 0; r < MAXH; r++) begin
        cur[c][r] = 1'b0;
        nxt[c][r] = 1'b0;
      end
    end

    for (int i = 0; i < WIDTH1; i++) begin
      for (int j = 0; j < WIDTH2; j++) begin
        cur[i+j][h[i+j]] = (a[i] & b[j]) ^ (tc & ((i == WIDTH1-1) != (j == WIDTH2-1)));
        h[i+j]++;
      end
    end
    // Baugh-Wooley constants 2^(W1-1) + 2^(W2-1) + 2^(PW-1), only in signed mode
    cur[WIDTH1-1][h[WIDTH1-1]] = tc;
    h[WIDTH1-1]++;
    cur[WIDTH2-1][h[WIDTH2-1]] = tc;
    h[WIDTH2-1]++;
    cur[PW-1][h[PW-1]] = tc;
    h[PW-1]++;

    d[0] = 2;
    for (int s = 1; s < NDS; s++) begin
      d[s] = (d[s-1] * 3) / 2;
    end

    for (int s = NDS - 1; s >= 0; s--) begin
      hmax = 0;
      for (int c = 0; c < PW; c++) begin
        if (h[c] > hmax) hmax = h[c];
      end
      if (hmax > d[s]) begin
        for (int c = 0; c < PW; c++) begin
          nh[c] = 0;
        end
        for (int c = 0; c < PW; c++) begin
          idx = 0;
          for (int t = 0; t < MAXH; t++) begin
            excess = h[c] - idx + nh[c] - d[s];
            if (excess > 0 && h[c] - idx >= 2) begin
              if (excess == 1 || h[c] - idx < 3) begin
                nxt[c][nh[c]] = cur[c][idx] ^ cur[c][idx+1];
                cy            = cur[c][idx] & cur[c][idx+1];
                idx           = idx + 2;
              end else begin
                nxt[c][nh[c]] = cur[c][idx] ^ cur[c][idx+1] ^ cur[c][idx+2];
                cy            = (cur[c][idx] & cur[c][idx+1]) |
                                (cur[c][idx] & cur[c][idx+2]) |
                                (cur[c][idx+1] & cur[c][idx+2]);
                idx           = idx + 3;
              end
              nh[c]++;
              if (c < PW - 1) begin
                nxt[c+1][nh[c+1]] = cy;
                nh[c+1]++;
              end
            end
          end
          for (int r = 0; r < MAXH; r++) begin
            if (r >= idx && r < h[c]) begin
              nxt[c][nh[c]] = cur[c][r];
              nh[c]++;
            end
          end
        end
        cur = nxt;
        for (int c = 0; c < PW; c++) begin
          h[c] = nh[c];
        end
      end
    end

    for (int c = 0; c < PW; c++) begin
      v0[c] = (h[c] > 0) ? cur[c][0] : 1'b0;
      v1[c] = (h[c] > 1) ? cur[c][1] : 1'b0;
    end
    return {v1, v0};
  endfunction

  logic stall;
  logic adv;

  logic              s1_valid_q;
  logic [WIDTH1-1:0] s1_a_q;
  logic [WIDTH2-1:0] s1_b_q;
  logic              s1_tc_q;
  logic              s1_clr_q;
  logic              s1_en_q;

  logic [PW-1:0]     v0_d;
  logic [PW-1:0]     v1_d;
  logic              s2_valid_q;
  logic [PW-1:0]     s2_v0_q;
  logic [PW-1:0]     s2_v1_q;
  logic              s2_tc_q;
  logic              s2_clr_q;
  logic              s2_en_q;

  logic [PW-1:0]     prod;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W:0]    sum_wide;
  logic              sovf;

  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  acc_out_q, acc_out_d;
  logic              ovf_q, ovf_d;

  assign stall       = out_valid_q & ~out_ready_i;
  assign adv         = ~stall;
  assign in_ready_o  = adv;
  assign out_valid_o = out_valid_q;
  assign acc_out_o   = acc_out_q;
  assign ovf_o       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tc_q    <= 1'b0;
      s1_clr_q   <= 1'b0;
      s1_en_q    <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid_i;
      s1_a_q     <= a_i;
      s1_b_q     <= b_i;
      s1_tc_q    <= tc_i;
      s1_clr_q   <= acc_clr_i;
      s1_en_q    <= acc_en_i;
    end
  end

  always_comb begin
    {v1_d, v0_d} = dadda_reduce(s1_a_q, s1_b_q, s1_tc_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_v0_q    <= '0;
      s2_v1_q    <= '0;
      s2_tc_q    <= 1'b0;
      s2_clr_q   <= 1'b0;
      s2_en_q    <= 1'b0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_v0_q    <= v0_d;
      s2_v1_q    <= v1_d;
      s2_tc_q    <= s1_tc_q;
      s2_clr_q   <= s1_clr_q;
      s2_en_q    <= s1_en_q;
    end
  end

  assign prod               = s2_v0_q + s2_v1_q;
  assign prod_ext[PW-1:0]   = prod;
  for (genvar gi = PW; gi < ACC_W; gi++) begin : g_ext
    assign prod_ext[gi] = s2_tc_q & prod[PW-1];
  end

  assign sum_wide = {1'b0, acc_q} + {1'b0, prod_ext};
  assign sovf     = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (sum_wide[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    ovf_d       = ovf_q;
    if (adv) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        if (s2_clr_q) begin
          acc_d     = prod_ext;
          acc_out_d = prod_ext;
          ovf_d     = 1'b0;
        end else if (s2_en_q) begin
          acc_d     = sum_wide[ACC_W-1:0];
          acc_out_d = sum_wide[ACC_W-1:0];
          ovf_d     = s2_tc_q ? sovf : sum_wide[ACC_W];
        end else begin
          acc_out_d = prod_ext;
          ovf_d     = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipe_mult_acc.sv
// Directed-vector bench for pipe_mult_acc: a 24-bit and a 16-bit accumulator
// instance see the same stimulus; results are checked against hand-computed values.
module tb_pipe_mult_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, tc, acc_clr, acc_en, out_ready;
  logic [7:0]  a, b;
  logic        in_ready, out_valid, ovf;
  logic [23:0] acc_out;
  logic        in_ready16, out_valid16, ovf16;
  logic [15:0] acc_out16;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        tc;
    logic        clr;
    logic        en;
    logic [23:0] exp_acc;
    logic        exp_ovf24;
    logic        exp_ovf16;
  } vec_t;

  vec_t cur [16];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   extra;

  always #5 clk = ~clk;

  pipe_mult_acc #(.WIDTH1(8), .WIDTH2(8), .ACC_W(24)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .tc_i        (tc),
    .acc_clr_i   (acc_clr),
    .acc_en_i    (acc_en),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .acc_out_o   (acc_out),
    .ovf_o       (ovf)
  );

  pipe_mult_acc #(.WIDTH1(8), .WIDTH2(8), .ACC_W(16)) u_dut16 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready16),
    .a_i         (a),
    .b_i         (b),
    .tc_i        (tc),
    .acc_clr_i   (acc_clr),
    .acc_en_i    (acc_en),
    .out_valid_o (out_valid16),
    .out_ready_i (out_ready),
    .acc_out_o   (acc_out16),
    .ovf_o       (ovf16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v, input logic vld);
    in_valid = vld;
    a        = v.a;
    b        = v.b;
    tc       = v.tc;
    acc_clr  = v.clr;
    acc_en   = v.en;
  endtask

  // Streams cur[0..n-1] back to back; out_ready is low for cycle indices st_lo..st_hi.
  task automatic run_stream(input int n, input int st_lo, input int st_hi);
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    int xtra = 0;
    while (got < n && cyc < 200) begin
      @(posedge clk);
      #1;
      out_ready = !(cyc >= st_lo && cyc <= st_hi);
      if (sent < n) drive(cur[sent], 1'b1);
      else in_valid = 1'b0;
      #1;
      if (out_valid && !out_ready) begin
        check($sformatf("stall_in_ready[%0d]", cyc), 32'(in_ready), 32'd0);
        check($sformatf("stall_hold[%0d]", cyc), 32'(acc_out), 32'(cur[got].exp_acc));
      end
      if (out_valid && out_ready) begin
        $display("rx %0d: acc_out=0x%06h ovf=%0d acc_out16=0x%04h ovf16=%0d",
                 got, acc_out, ovf, acc_out16, ovf16);
        check($sformatf("acc24[%0d]", got), 32'(acc_out), 32'(cur[got].exp_acc));
        check($sformatf("ovf24[%0d]", got), 32'(ovf), 32'(cur[got].exp_ovf24));
        check($sformatf("valid16[%0d]", got), 32'(out_valid16), 32'd1);
        check($sformatf("acc16[%0d]", got), 32'(acc_out16), 32'(cur[got].exp_acc[15:0]));
        check($sformatf("ovf16[%0d]", got), 32'(ovf16), 32'(cur[got].exp_ovf16));
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    check("stream_count", 32'(got), 32'(n));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #2;
      if (out_valid || out_valid16) xtra++;
    end
    check("no_extra", 32'(xtra), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 8'd0;
    b         = 8'd0;
    tc        = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_acc_out", 32'(acc_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_out_valid16", 32'(out_valid16), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single beat: latency is exactly three cycles
    v = '{8'd255, 8'd255, 1'b0, 1'b1, 1'b0, 24'h00FE01, 1'b0, 1'b0};
    drive(v, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    check("lat_c1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #2;
    check("lat_c2", 32'(out_valid), 32'd0);
    @(posedge clk);
    #2;
    check("lat_c3", 32'(out_valid), 32'd1);
    check("lat_acc", 32'(acc_out), 32'h00FE01);
    check("lat_ovf", 32'(ovf), 32'd0);
    $display("rx lat: acc_out=0x%06h ovf=%0d", acc_out, ovf);
    @(posedge clk);
    #2;
    check("lat_drain", 32'(out_valid), 32'd0);

    //          a       b       tc    clr   en    acc24        ovf24 ovf16
    cur[0]  = '{8'd255, 8'd255, 1'b0, 1'b1, 1'b0, 24'h00FE01, 1'b0, 1'b0};
    cur[1]  = '{8'h80,  8'h7F,  1'b1, 1'b1, 1'b0, 24'hFFC080, 1'b0, 1'b0};
    cur[2]  = '{8'd3,   8'd4,   1'b0, 1'b1, 1'b0, 24'd12,     1'b0, 1'b0};
    cur[3]  = '{8'd5,   8'd6,   1'b0, 1'b0, 1'b1, 24'd42,     1'b0, 1'b0};
    cur[4]  = '{8'd2,   8'd2,   1'b0, 1'b0, 1'b0, 24'd4,      1'b0, 1'b0};
    cur[5]  = '{8'd7,   8'd8,   1'b0, 1'b0, 1'b1, 24'd98,     1'b0, 1'b0};
    cur[6]  = '{8'd255, 8'd255, 1'b0, 1'b1, 1'b0, 24'h00FE01, 1'b0, 1'b0};
    cur[7]  = '{8'd255, 8'd255, 1'b0, 1'b0, 1'b1, 24'h01FC02, 1'b0, 1'b1};
    cur[8]  = '{8'd127, 8'd127, 1'b1, 1'b1, 1'b0, 24'h003F01, 1'b0, 1'b0};
    cur[9]  = '{8'd127, 8'd127, 1'b1, 1'b0, 1'b1, 24'h007E02, 1'b0, 1'b0};
    cur[10] = '{8'd127, 8'd127, 1'b1, 1'b0, 1'b1, 24'h00BD03, 1'b0, 1'b1};
    cur[11] = '{8'hFF,  8'h01,  1'b1, 1'b0, 1'b1, 24'h00BD02, 1'b0, 1'b0};
    cur[12] = '{8'h80,  8'h80,  1'b1, 1'b1, 1'b0, 24'h004000, 1'b0, 1'b0};
    cur[13] = '{8'h80,  8'h01,  1'b1, 1'b0, 1'b1, 24'h003F80, 1'b0, 1'b0};
    cur[14] = '{8'hFF,  8'hFF,  1'b1, 1'b0, 1'b0, 24'h000001, 1'b0, 1'b0};
    cur[15] = '{8'hFF,  8'hFF,  1'b0, 1'b0, 1'b1, 24'h013D81, 1'b0, 1'b1};
    run_stream(16, 1000, -1);

    // Backpressure: six squares accumulated, sink stalls in cycles 4..8
    cur[0] = '{8'd1, 8'd1, 1'b0, 1'b1, 1'b0, 24'd1,  1'b0, 1'b0};
    cur[1] = '{8'd2, 8'd2, 1'b0, 1'b0, 1'b1, 24'd5,  1'b0, 1'b0};
    cur[2] = '{8'd3, 8'd3, 1'b0, 1'b0, 1'b1, 24'd14, 1'b0, 1'b0};
    cur[3] = '{8'd4, 8'd4, 1'b0, 1'b0, 1'b1, 24'd30, 1'b0, 1'b0};
    cur[4] = '{8'd5, 8'd5, 1'b0, 1'b0, 1'b1, 24'd55, 1'b0, 1'b0};
    cur[5] = '{8'd6, 8'd6, 1'b0, 1'b0, 1'b1, 24'd91, 1'b0, 1'b0};
    run_stream(6, 4, 8);

    // Reset while two beats are in flight
    @(posedge clk);
    #1;
    v = '{8'd9, 8'd9, 1'b0, 1'b1, 1'b0, 24'd81, 1'b0, 1'b0};
    drive(v, 1'b1);
    @(posedge clk);
    #1;
    v = '{8'd1, 8'd1, 1'b0, 1'b0, 1'b1, 24'd82, 1'b0, 1'b0};
    drive(v, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    check("mid_pre_acc", 32'(acc_out), 32'd81);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_acc", 32'(acc_out), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_valid16", 32'(out_valid16), 32'd0);
    check("mid_rst_acc16", 32'(acc_out16), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #2;
      if (out_valid || out_valid16) extra++;
    end
    check("mid_no_output", 32'(extra), 32'd0);
    cur[0] = '{8'd2, 8'd3, 1'b0, 1'b0, 1'b1, 24'd6, 1'b0, 1'b0};
    run_stream(1, 1000, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
